// File: rtl/maxpool_l1.sv
// maxpool_l1: 2x2 stride-2 max pooling of a 64x64 layer-0 map into a 32x32 layer-1 map
module maxpool_l1 #(
  parameter int DW = 20,
  parameter logic [2:0] L0_SEL = 3'b001,
  parameter logic [2:0] L1_SEL = 3'b011
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 crd,
  output logic [11:0]          caddr_rd,
  input  logic signed [DW-1:0] cdata_rd,
  output logic                 cwr,
  output logic [11:0]          caddr_wr,
  output logic signed [DW-1:0] cdata_wr,
  output logic [2:0]           csel
);
  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CMP, WR, FIN} state_t;
  state_t state;
  logic [4:0] r, c, nr, nc;
  logic signed [DW-1:0] max_v, max_n;
  logic last;
  // running max against the word arriving this cycle; ties keep the held value
  assign max_n = (cdata_rd > max_v) ? cdata_rd : max_v;
  assign last = &{r, c};
  assign nc = c + 5'd1;
  assign nr = (&c) ? r + 5'd1 : r;
  // sequencer: every output is registered one cycle ahead of the state it belongs to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= 3'b000;
      r        <= '0;
      c        <= '0;
      max_v    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= RD0;
          busy     <= 1'b1;
          r        <= '0;
          c        <= '0;
          crd      <= 1'b1;
          csel     <= L0_SEL;
          caddr_rd <= '0;
        end
        RD0: begin
          state    <= RD1;
          caddr_rd <= {r, 1'b0, c, 1'b1};
        end
        RD1: begin
          state    <= RD2;
          max_v    <= cdata_rd;
          caddr_rd <= {r, 1'b1, c, 1'b0};
        end
        RD2: begin
          state    <= RD3;
          max_v    <= max_n;
          caddr_rd <= {r, 1'b1, c, 1'b1};
        end
        RD3: begin
          state <= CMP;
          max_v <= max_n;
          crd   <= 1'b0;
          csel  <= 3'b000;
        end
        CMP: begin
          state    <= WR;
          max_v    <= max_n;
          cwr      <= 1'b1;
          csel     <= L1_SEL;
          caddr_wr <= {2'b00, r, c};
          cdata_wr <= max_n;
        end
        WR: begin
          cwr <= 1'b0;
          if (last) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            csel  <= 3'b000;
          end else begin
            state    <= RD0;
            r        <= nr;
            c        <= nc;
            crd      <= 1'b1;
            csel     <= L0_SEL;
            caddr_rd <= {nr, 1'b0, nc, 1'b0};
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool_l1.sv
// tb_maxpool_l1: directed bench for maxpool_l1 with layer-0/layer-1 memory models
module tb_maxpool_l1;
  localparam int DW = 20;
  localparam logic [2:0] L0 = 3'b001;
  localparam logic [2:0] L1 = 3'b011;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [DW-1:0] rdata, cdata_wr;
  logic [2:0] csel;
  logic [DW-1:0] l0 [4096];
  logic [DW-1:0] l1 [1024];
  int total = 0;
  int bad = 0;
  int rd_k = 0, rd_err = 0, wcount = 0, seq_err = 0, done_cnt = 0, viol = 0;

  maxpool_l1 #(.DW(DW), .L0_SEL(L0), .L1_SEL(L1)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(rdata), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_rd(input int k);
    int o = k / 4;
    int q = k % 4;
    return 12'(128 * (o / 32) + 2 * (o % 32) + (q % 2) + 64 * (q / 2));
  endfunction

  // memories plus read/write sequence trackers, cleared when a start is accepted
  always @(posedge clk) begin
    if (crd && csel == L0) rdata <= l0[caddr_rd];
    if (start && !busy && reset) begin
      rd_k <= 0; rd_err <= 0; wcount <= 0; seq_err <= 0; done_cnt <= 0;
    end else begin
      if (crd) begin
        if (caddr_rd !== exp_rd(rd_k)) rd_err <= rd_err + 1;
        rd_k <= rd_k + 1;
      end
      if (cwr) begin
        if (csel == L1) l1[caddr_wr[9:0]] <= cdata_wr;
        if (caddr_wr !== wcount[11:0]) seq_err <= seq_err + 1;
        wcount <= wcount + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // strobe exclusivity and bank select rules, sampled mid-cycle
  always @(negedge clk)
    if ((crd && cwr) || csel !== (crd ? L0 : cwr ? L1 : 3'b000)) viol <= viol + 1;

  task automatic run_pool(input int restart_at, output int n, output int first_wr, output logic busy1);
    n = 0; first_wr = -1; busy1 = 1'b0; start = 1'b1;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin start = 1'b0; busy1 = busy; end
      if (n == restart_at) start = 1'b1;
      if (n == restart_at + 1) start = 1'b0;
      if (cwr && first_wr < 0) first_wr = n;
    end while (!done && n < 8000);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int act;
    #2 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done); end
    total++; if (crd !== 1'b0 || cwr !== 1'b0) begin bad++; $display("FAIL reset_strobes crd=%b cwr=%b want 0 0", crd, cwr); end
    total++; if (caddr_rd !== 12'd0 || caddr_wr !== 12'd0) begin bad++; $display("FAIL reset_addr rd=%0d wr=%0d want 0 0", caddr_rd, caddr_wr); end
    total++; if (cdata_wr !== '0 || csel !== 3'b000) begin bad++; $display("FAIL reset_data data=%h csel=%b want 0 000", cdata_wr, csel); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    act = 0;
    repeat (10) begin @(posedge clk); #1; if (busy || crd || cwr || done) act++; end
    total++; if (act !== 0) begin bad++; $display("FAIL idle_after_reset active_cycles=%0d want 0", act); end
  endtask

  task automatic test_ramp;
    int n, fw;
    logic b1;
    for (int a = 0; a < 4096; a++) l0[a] = DW'(a);
    run_pool(100, n, fw, b1);
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL ramp_busy_first got=%b want 1", b1); end
    total++; if (fw !== 6) begin bad++; $display("FAIL ramp_first_write cycle=%0d want 6", fw); end
    total++; if (n !== 6145) begin bad++; $display("FAIL ramp_done_latency cycle=%0d want 6145", n); end
    total++; if (l1[0] !== 20'd65) begin bad++; $display("FAIL ramp_l1_0 got=%0d want 65", l1[0]); end
    total++; if (l1[1] !== 20'd67) begin bad++; $display("FAIL ramp_l1_1 got=%0d want 67", l1[1]); end
    total++; if (l1[32] !== 20'd193) begin bad++; $display("FAIL ramp_l1_32 got=%0d want 193", l1[32]); end
    total++; if (l1[1023] !== 20'd4095) begin bad++; $display("FAIL ramp_l1_1023 got=%0d want 4095", l1[1023]); end
    total++; if (wcount !== 1024 || seq_err !== 0) begin bad++; $display("FAIL ramp_writes count=%0d seq_err=%0d want 1024 0", wcount, seq_err); end
    total++; if (rd_k !== 4096 || rd_err !== 0) begin bad++; $display("FAIL ramp_reads count=%0d addr_err=%0d want 4096 0", rd_k, rd_err); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ramp_single_done got=%0d want 1", done_cnt); end
  endtask

  task automatic test_negative;
    int n, fw, odd;
    logic b1;
    for (int a = 0; a < 4096; a++) l0[a] = 20'hFFFF0;
    l0[65] = 20'hFFFF8;
    run_pool(0, n, fw, b1);
    odd = 0;
    for (int i = 1; i < 1024; i++) if (l1[i] !== 20'hFFFF0) odd++;
    total++; if (l1[0] !== 20'hFFFF8) begin bad++; $display("FAIL neg_l1_0 got=%h want FFFF8", l1[0]); end
    total++; if (odd !== 0) begin bad++; $display("FAIL neg_others wrong_count=%0d want 0", odd); end
    total++; if (n !== 6145) begin bad++; $display("FAIL neg_done_latency cycle=%0d want 6145", n); end
  endtask

  task automatic test_tie_signed;
    int n, fw;
    logic b1;
    for (int a = 0; a < 4096; a++) l0[a] = '0;
    l0[0] = 20'd5; l0[1] = 20'd5; l0[64] = 20'd5; l0[65] = 20'd5;
    l0[4] = 20'hFFFFF; l0[5] = 20'd3; l0[68] = 20'h80000; l0[69] = 20'd2;
    l0[6] = 20'd9;
    run_pool(0, n, fw, b1);
    total++; if (l1[0] !== 20'd5) begin bad++; $display("FAIL tie_l1_0 got=%0d want 5", l1[0]); end
    total++; if (l1[1] !== 20'd0) begin bad++; $display("FAIL tie_l1_1 got=%0d want 0", l1[1]); end
    total++; if (l1[2] !== 20'd3) begin bad++; $display("FAIL signed_l1_2 got=%h want 00003", l1[2]); end
    total++; if (l1[3] !== 20'd9) begin bad++; $display("FAIL first_sample_l1_3 got=%0d want 9", l1[3]); end
    total++; if (wcount !== 1024) begin bad++; $display("FAIL tie_write_count got=%0d want 1024", wcount); end
  endtask

  task automatic test_mid_reset;
    int n, fw, act;
    logic b1;
    for (int a = 0; a < 4096; a++) l0[a] = DW'(a);
    start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    total++; if (crd !== 1'b1 || caddr_rd !== 12'd68) begin bad++; $display("FAIL mid_rd2_addr crd=%b addr=%0d want 1 68", crd, caddr_rd); end
    reset = 1'b0;
    #1;
    total++; if ({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel} !== '0) begin bad++; $display("FAIL mid_reset_outputs busy=%b crd=%b rd=%0d wr=%0d data=%h csel=%b want all 0", busy, crd, caddr_rd, caddr_wr, cdata_wr, csel); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    act = 0;
    repeat (20) begin @(posedge clk); #1; if (busy || crd || cwr || done) act++; end
    total++; if (act !== 0) begin bad++; $display("FAIL mid_idle active_cycles=%0d want 0", act); end
    total++; if (wcount !== 2) begin bad++; $display("FAIL mid_aborted_writes got=%0d want 2", wcount); end
    run_pool(0, n, fw, b1);
    total++; if (n !== 6145 || done_cnt !== 1) begin bad++; $display("FAIL rerun_done cycle=%0d dones=%0d want 6145 1", n, done_cnt); end
    total++; if (l1[0] !== 20'd65 || l1[1023] !== 20'd4095) begin bad++; $display("FAIL rerun_values l1_0=%0d l1_1023=%0d want 65 4095", l1[0], l1[1023]); end
    total++; if (rd_err !== 0 || seq_err !== 0) begin bad++; $display("FAIL rerun_seq rd_err=%0d wr_err=%0d want 0 0", rd_err, seq_err); end
  endtask

  task automatic test_protocol;
    total++; if (viol !== 0) begin bad++; $display("FAIL protocol violations=%0d want 0", viol); end
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_negative;
    test_tie_signed;
    test_mid_reset;
    test_protocol;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
